// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller.
// - state_e    : controller FSM states
// - INIT_CMDS  : power-up command table, entry 0 is sent first
// - CMD_*      : panel commands issued by the controller itself
// - CLEAR_CHAR : byte that, when pushed, clears the panel instead of printing
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR,
    LOAD,
    SETUP,
    EN_HI,
    HOLD,
    WAIT,
    IDLE
  } state_e;

  localparam int unsigned CNT_W    = 20;
  localparam int unsigned INIT_LEN = 5;

  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_LINE1  = 8'h80;
  localparam logic [7:0] CMD_LINE2  = 8'hC0;
  localparam logic [7:0] CLEAR_CHAR = 8'hFE;

  // Function set 8-bit/2-line, display on, clear, entry mode, home line 1.
  localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h80, 8'h06, 8'h01, 8'h0C, 8'h38};

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    cmd = 8'h00;
    for (int i = 0; i < int'(INIT_LEN); i++) begin
      if (idx == 3'(i)) cmd = INIT_CMDS[i];
    end
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Processor push port and panel pins of the LCD controller.
// - lcd_write/lcd_data : push strobe and byte (bits [7:0] used)
// - fifo_full/init_done: status back to the processor
// - lcd_en/rs/rw/on/db : panel pins
// master = processor/panel side, slave = controller.
interface lcd_ctrl_if;
  logic        lcd_write;
  logic [31:0] lcd_data;
  logic        fifo_full;
  logic        init_done;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_on;
  logic [7:0]  lcd_db;

  modport master (
    output lcd_write, lcd_data,
    input  fifo_full, init_done, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_db
  );

  modport slave (
    input  lcd_write, lcd_data,
    output fifo_full, init_done, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_db
  );
endinterface

// File: rtl/lcd_fifo.sv
// 8-entry x 8-bit synchronous FIFO with first-word fall-through read.
// - clock, reset : rising-edge clock, async active-high reset (empties FIFO)
// - i_push/i_din : write strobe and byte; ignored while full
// - i_pop        : read strobe; ignored while empty
// - o_dout       : head entry, valid while !o_empty
// - o_full/o_empty
module lcd_fifo (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);
  localparam int unsigned Depth = 8;

  logic [7:0] r_mem [Depth];
  logic [2:0] r_wr;
  logic [2:0] r_rd;
  logic [3:0] r_cnt;
  logic       w_push;
  logic       w_pop;

  assign o_full  = (r_cnt == 4'(Depth));
  assign o_empty = (r_cnt == 4'd0);
  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr  <= 3'd0;
      r_rd  <= 3'd0;
      r_cnt <= 4'd0;
    end else begin
      if (w_push) r_wr <= r_wr + 3'd1;
      if (w_pop)  r_rd <= r_rd + 3'd1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD controller: power-up wait, init command
// sequence, then drains a byte FIFO to the panel with per-transfer timing
// SETUP(1) / EN_HI(EN_HIGH) / HOLD(1) / WAIT(CMD_WAIT or CLR_WAIT).
// - clock, reset : rising-edge clock, async active-high reset
// - bus          : lcd_ctrl_if slave (push port, status, panel pins)
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWR_WAIT = 750000,
  parameter int unsigned EN_HIGH  = 16,
  parameter int unsigned CMD_WAIT = 2000,
  parameter int unsigned CLR_WAIT = 82000
) (
  input  logic       clock,
  input  logic       reset,
  lcd_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] PwrLast = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] EnLast  = CNT_W'(EN_HIGH - 1);
  localparam logic [CNT_W-1:0] CmdLast = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] ClrLast = CNT_W'(CLR_WAIT - 1);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx, w_idx_d;
  logic [4:0]       r_col, w_col_d;
  logic [7:0]       r_db, w_db_d;
  logic             r_rs, w_rs_d;

  logic             w_pop, w_empty, w_init_done, w_line_pend;
  logic [7:0]       w_dout;
  logic [CNT_W-1:0] w_wait_last;
  logic             w_unused_data;

  lcd_fifo u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.lcd_write),
    .i_din   (bus.lcd_data[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (bus.fifo_full),
    .o_empty (w_empty)
  );

  assign w_unused_data = ^bus.lcd_data[31:8];
  // Init index runs past the last table entry to mark completion.
  assign w_init_done   = (r_idx == 3'(INIT_LEN));
  // A data write that left the cursor at a line start owes a cursor command.
  assign w_line_pend   = r_rs && ((r_col == 5'd16) || (r_col == 5'd0));
  assign w_wait_last   = (!r_rs && (r_db == CMD_CLEAR)) ? ClrLast : CmdLast;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_col_d   = r_col;
    w_db_d    = r_db;
    w_rs_d    = r_rs;
    w_pop     = 1'b0;
    unique case (r_state)
      PWR:   if (r_cnt == PwrLast) w_state_d = LOAD;
      LOAD: begin
        w_db_d    = init_cmd(r_idx);
        w_rs_d    = 1'b0;
        w_state_d = SETUP;
      end
      SETUP: w_state_d = EN_HI;
      EN_HI: if (r_cnt == EnLast) w_state_d = HOLD;
      HOLD:  w_state_d = WAIT;
      WAIT: begin
        if (r_cnt == w_wait_last) begin
          if (!w_init_done) begin
            w_idx_d   = r_idx + 3'd1;
            w_state_d = (r_idx == 3'(INIT_LEN - 1)) ? IDLE : LOAD;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (w_line_pend) begin
          w_db_d    = (r_col == 5'd16) ? CMD_LINE2 : CMD_LINE1;
          w_rs_d    = 1'b0;
          w_state_d = SETUP;
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = SETUP;
          if (w_dout == CLEAR_CHAR) begin
            w_db_d  = CMD_CLEAR;
            w_rs_d  = 1'b0;
            w_col_d = 5'd0;
          end else begin
            w_db_d  = w_dout;
            w_rs_d  = 1'b1;
            w_col_d = r_col + 5'd1;
          end
        end
      end
      default: w_state_d = PWR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= PWR;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_col   <= 5'd0;
      r_db    <= 8'h00;
      r_rs    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      // Counter restarts on every state entry.
      r_cnt   <= (w_state_d != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_idx   <= w_idx_d;
      r_col   <= w_col_d;
      r_db    <= w_db_d;
      r_rs    <= w_rs_d;
    end
  end

  assign bus.lcd_en    = (r_state == EN_HI);
  assign bus.lcd_rs    = r_rs;
  assign bus.lcd_db    = r_db;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_on    = 1'b1;
  assign bus.init_done = w_init_done;
endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with PWR_WAIT=20, EN_HIGH=2, CMD_WAIT=4, CLR_WAIT=8.
// A negedge monitor records every lcd_en pulse (rs, db, length, start cycle
// relative to reset release) and counts rs/db changes around the pulse.
module tb_lcd_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .PWR_WAIT (20),
    .EN_HIGH  (2),
    .CMD_WAIT (4),
    .CLR_WAIT (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         len;
    int         start;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         start;  // -1: start cycle not checked
  } vec_t;

  pulse_t     pq[$];
  pulse_t     cur;
  vec_t       tv[13];
  vec_t       ev[$];
  int         cyc = 0;
  int         rel = 0;
  int         unstable = 0;
  int         done_cyc = -1;
  bit         in_p = 1'b0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_db = 8'h00;
  int         total = 0;
  int         bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      in_p = 1'b0;
    end else begin
      if (bus.lcd_en && !in_p) begin
        in_p      = 1'b1;
        cur.rs    = bus.lcd_rs;
        cur.db    = bus.lcd_db;
        cur.len   = 1;
        cur.start = cyc - rel;
        if (prev_rs !== bus.lcd_rs || prev_db !== bus.lcd_db) unstable++;
      end else if (bus.lcd_en && in_p) begin
        cur.len++;
        if (cur.rs !== bus.lcd_rs || cur.db !== bus.lcd_db) unstable++;
      end else if (!bus.lcd_en && in_p) begin
        in_p = 1'b0;
        if (cur.rs !== bus.lcd_rs || cur.db !== bus.lcd_db) unstable++;
        pq.push_back(cur);
      end
      if (bus.init_done === 1'b1 && done_cyc < 0) done_cyc = cyc - rel;
      prev_rs = bus.lcd_rs;
      prev_db = bus.lcd_db;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Caller is at a negedge; reset lands before the next posedge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst.lcd_en", int'(bus.lcd_en), 0);
    chk("rst.lcd_rs", int'(bus.lcd_rs), 0);
    chk("rst.lcd_rw", int'(bus.lcd_rw), 0);
    chk("rst.lcd_db", int'(bus.lcd_db), 0);
    chk("rst.lcd_on", int'(bus.lcd_on), 1);
    chk("rst.init_done", int'(bus.init_done), 0);
    chk("rst.fifo_full", int'(bus.fifo_full), 0);
    repeat (3) @(negedge clock);
    pq.delete();
    done_cyc = -1;
    rel      = cyc;
    reset    = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clock);
    bus.lcd_write = 1'b1;
    bus.lcd_data  = {24'hA5A5A5, b};
    @(negedge clock);
    bus.lcd_write = 1'b0;
  endtask

  task automatic push_fc(input logic [7:0] b);
    int k = 0;
    @(negedge clock);
    while (bus.fifo_full && k < 60) begin
      @(negedge clock);
      k++;
    end
    if (bus.fifo_full) chk("push_fc.space_timeout", 1, 0);
    bus.lcd_write = 1'b1;
    bus.lcd_data  = {24'h3C3C3C, b};
    @(negedge clock);
    bus.lcd_write = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    int k = 0;
    while (pq.size() < n && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk($sformatf("%s.pulses_reached", tag), int'(pq.size() >= n), 1);
  endtask

  task automatic check_pulse(input string tag, input int i, input vec_t v);
    if (i < pq.size()) begin
      chk($sformatf("%s[%0d].rs", tag, i), int'(pq[i].rs), int'(v.rs));
      chk($sformatf("%s[%0d].db", tag, i), int'(pq[i].db), int'(v.db));
      chk($sformatf("%s[%0d].len", tag, i), pq[i].len, 2);
      if (v.start >= 0) chk($sformatf("%s[%0d].start", tag, i), pq[i].start, v.start);
    end else begin
      chk($sformatf("%s[%0d].present", tag, i), 0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.lcd_write = 1'b0;
    bus.lcd_data  = 32'h0;

    // Init commands, then the 8 bytes queued during PWR.
    tv[0]  = '{1'b0, 8'h38, 22};
    tv[1]  = '{1'b0, 8'h0C, 31};
    tv[2]  = '{1'b0, 8'h01, 40};
    tv[3]  = '{1'b0, 8'h06, 53};
    tv[4]  = '{1'b0, 8'h80, 62};
    tv[5]  = '{1'b1, 8'h30, 71};
    tv[6]  = '{1'b1, 8'h31, 80};
    tv[7]  = '{1'b1, 8'h32, 89};
    tv[8]  = '{1'b1, 8'h33, 98};
    tv[9]  = '{1'b1, 8'h34, 107};
    tv[10] = '{1'b1, 8'h35, 116};
    tv[11] = '{1'b1, 8'h36, 125};
    tv[12] = '{1'b1, 8'h37, 134};

    // Power-up, init sequence, and overflow of the FIFO during PWR.
    @(negedge clock);
    do_reset();
    @(negedge clock);
    bus.lcd_write = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.lcd_data = {24'h5A5A5A, 8'h30 + 8'(i)};
      @(negedge clock);
      #1;
      if (i == 6) chk("full_after_7", int'(bus.fifo_full), 0);
      if (i == 7) chk("full_after_8", int'(bus.fifo_full), 1);
      if (i == 8) chk("full_after_9", int'(bus.fifo_full), 1);
    end
    bus.lcd_write = 1'b0;
    wait_pulses("boot", 13, 400);
    repeat (40) @(negedge clock);
    chk("boot.pulse_count", pq.size(), 13);
    for (int i = 0; i < 13; i++) check_pulse("boot", i, tv[i]);
    chk("boot.init_done_cycle", done_cyc, 69);
    chk("boot.init_done", int'(bus.init_done), 1);

    // Single data byte, then pop-to-pop spacing.
    pq.delete();
    push_byte(8'h41);
    push_byte(8'h42);
    wait_pulses("pair", 2, 100);
    repeat (20) @(negedge clock);
    chk("pair.pulse_count", pq.size(), 2);
    check_pulse("pair", 0, '{1'b1, 8'h41, -1});
    check_pulse("pair", 1, '{1'b1, 8'h42, -1});
    if (pq.size() >= 2) chk("pair.spacing", pq[1].start - pq[0].start, 9);

    // Line wrap: 0xC0 after char 16, 0x80 after char 32.
    @(negedge clock);
    do_reset();
    wait_pulses("wrap.init", 5, 200);
    repeat (10) @(negedge clock);
    pq.delete();
    for (int i = 0; i < 33; i++) push_fc(8'h61 + 8'(i));
    ev.delete();
    for (int i = 0; i < 16; i++) ev.push_back('{1'b1, 8'h61 + 8'(i), -1});
    ev.push_back('{1'b0, 8'hC0, -1});
    for (int i = 16; i < 32; i++) ev.push_back('{1'b1, 8'h61 + 8'(i), -1});
    ev.push_back('{1'b0, 8'h80, -1});
    ev.push_back('{1'b1, 8'h81, -1});
    wait_pulses("wrap", 35, 1500);
    repeat (30) @(negedge clock);
    chk("wrap.pulse_count", pq.size(), 35);
    for (int i = 0; i < ev.size(); i++) check_pulse("wrap", i, ev[i]);

    // Clear char: command 0x01, long wait, cursor back to column 0.
    pq.delete();
    push_fc(8'hFE);
    for (int i = 0; i < 17; i++) push_fc(8'h41 + 8'(i));
    ev.delete();
    ev.push_back('{1'b0, 8'h01, -1});
    for (int i = 0; i < 16; i++) ev.push_back('{1'b1, 8'h41 + 8'(i), -1});
    ev.push_back('{1'b0, 8'hC0, -1});
    ev.push_back('{1'b1, 8'h51, -1});
    wait_pulses("clr", 19, 800);
    repeat (30) @(negedge clock);
    chk("clr.pulse_count", pq.size(), 19);
    for (int i = 0; i < ev.size(); i++) check_pulse("clr", i, ev[i]);
    if (pq.size() >= 2) chk("clr.wait_spacing", pq[1].start - pq[0].start, 13);

    // Reset during EN_HI with bytes still queued.
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    k = 0;
    while (!bus.lcd_en && k < 50) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("abort.en_before_reset", int'(bus.lcd_en), 1);
    do_reset();
    wait_pulses("abort", 5, 200);
    repeat (60) @(negedge clock);
    chk("abort.pulse_count", pq.size(), 5);
    for (int i = 0; i < 5; i++) check_pulse("abort", i, tv[i]);
    chk("abort.init_done_cycle", done_cyc, 69);

    chk("bus_stable_around_en", unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 The block SHALL take parameter PWR_WAIT, default 750000, meaning the number of cycles from reset release to the first command.
REQ-002 The block SHALL take parameter EN_HIGH, default 16, meaning the number of cycles lcd_en is held high per transfer.
REQ-003 The block SHALL take parameter CMD_WAIT, default 2000, meaning the number of idle cycles after a normal transfer.
REQ-004 The block SHALL take parameter CLR_WAIT, default 82000, meaning the number of idle cycles after a clear (0x01) command.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-006 The ports SHALL be:
- clock  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high
- lcd_write  input  1  one-cycle push strobe from the processor
- lcd_data  input  32  write data; only bits [7:0] are used
- fifo_full  output  1  high when 8 entries are queued
- init_done  output  1  high once the init sequence has completed
- lcd_en  output  1  panel enable strobe
- lcd_rs  output  1  panel register select: 0 = command, 1 = data
- lcd_rw  output  1  panel read/write select; tied 0
- lcd_on  output  1  panel power; 1 out of reset
- lcd_db  output  8  panel data bus

Function
REQ-007 The block SHALL push lcd_data[7:0] into an 8-deep FIFO on a rising edge where lcd_write=1 and fifo_full=0.
REQ-008 A push attempted while full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-009 A simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-010 The FIFO SHALL accept pushes during init; queued entries SHALL be drained only after init_done=1.
REQ-011 The FSM states SHALL be PWR, LOAD, SETUP, EN_HI, HOLD, WAIT and IDLE.
REQ-012 PWR SHALL count PWR_WAIT cycles, then go to LOAD with init index 0.
REQ-013 The init sequence, all with rs=0, SHALL be 0x38, 0x0C, 0x01, 0x06, 0x80; after the last one, init_done SHALL be set and the FSM SHALL go to IDLE.
REQ-014 For every transfer, SETUP SHALL last 1 cycle: lcd_db and lcd_rs driven, lcd_en=0.
REQ-015 For every transfer, EN_HI SHALL last EN_HIGH cycles with lcd_en=1, lcd_db and lcd_rs held stable.
REQ-016 For every transfer, HOLD SHALL last 1 cycle: lcd_en=0, lcd_db and lcd_rs still held.
REQ-017 For every transfer, WAIT SHALL last CMD_WAIT cycles, or CLR_WAIT when the byte was 0x01 with rs=0.
REQ-018 In IDLE with the FIFO non-empty, the block SHALL pop one byte (1 cycle) and start a transfer; in IDLE with the FIFO empty, it SHALL stay in IDLE with lcd_en=0.
REQ-019 Popped byte 0xFE SHALL be sent as command 0x01 (rs=0), SHALL use the CLR_WAIT wait, and SHALL set col=0.
REQ-020 Any other popped byte SHALL be sent as data (rs=1), and col SHALL then increment.
REQ-021 col SHALL be a 5-bit cursor, 0..31.
REQ-022 When col becomes 16 after a data write, the block SHALL issue command 0xC0 before the next pop.
REQ-023 When col wraps from 31 to 0, the block SHALL issue command 0x80 before the next pop.
REQ-024 The timing counter SHALL be 20 bits wide, saturate-free, and reload on every state entry.
REQ-025 Per-byte latency from pop to the end of WAIT SHALL be 1+1+EN_HIGH+1+wait cycles (pop, SETUP, EN_HI, HOLD, WAIT).
REQ-026 lcd_rw SHALL be constant 0; the block SHALL never read the panel.

Reset
REQ-027 While reset=1, the block SHALL immediately force: FSM to PWR, FIFO empty, col 0, init index 0, counter 0.
REQ-028 While reset=1, the outputs SHALL be lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, lcd_on=1, init_done=0, fifo_full=0.
REQ-029 A reset asserted mid-transfer SHALL abort that transfer with no further lcd_en pulse; the full PWR wait and init SHALL rerun after release.

Structure
REQ-030 Package lcd_pkg SHALL hold the state enum, the init command table, the constants CMD_CLEAR=0x01, CMD_LINE1=0x80, CMD_LINE2=0xC0, and CLEAR_CHAR=0xFE.
REQ-031 The block SHALL contain one sub-module, lcd_fifo: 8x8, synchronous, with push, pop, full, empty and dout, and with async active-high reset.
REQ-032 The top level SHALL hold only the FSM, counter, col and init index.

Verification
REQ-033 The bench SHALL run with parameters PWR_WAIT=20, EN_HIGH=2, CMD_WAIT=4, CLR_WAIT=8.
REQ-034 Scenario: release reset -> the first lcd_en rise SHALL occur 22 cycles after release with lcd_db=0x38; the 5 init commands SHALL follow, with an 8-cycle wait after 0x01; init_done SHALL be set.
REQ-035 Scenario: after init, push 0x41 -> exactly one 2-cycle lcd_en pulse with rs=1 and lcd_db=0x41; the next transfer SHALL be able to start 9 cycles after the pop.
REQ-036 Scenario: push 9 bytes back-to-back during PWR -> fifo_full=1 after the 8th push; the 9th byte SHALL be dropped; exactly 8 data writes SHALL follow init.
REQ-037 Scenario: push 17 chars 'a'..'q' -> a command 0xC0 pulse SHALL appear between the 16th and 17th data pulses; pushing 16 more SHALL produce 0x80 after the 32nd char.
REQ-038 Scenario: push 0xFE -> command 0x01 with rs=0 followed by an 8-cycle wait; the next char SHALL be written with col restarting at 0.
REQ-039 Scenario: assert reset during EN_HI -> lcd_en=0 in the same cycle; the FIFO SHALL be empty; the init sequence SHALL restart after PWR_WAIT.
